// File: rtl/jogo_sequencia_param.sv
// Parameterised sequence-memory game: the player repeats a stored button sequence, one extra step per round.
// Optional inactivity timeout in ESPERA is built only when JOGO_TIMEOUT_EN is defined.
module jogo_sequencia_param #(
    parameter int N_BOTOES       = 4,
    parameter int N_JOGADAS      = 16,
    parameter int TIMEOUT_CICLOS = 5000,
    localparam int AW            = $clog2(N_JOGADAS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                mem_escreve,
    input  logic [AW-1:0]       mem_endereco,
    input  logic [N_BOTOES-1:0] mem_dado,
    output logic                acertou,
    output logic                errou,
    output logic                pronto,
    output logic                timeout,
    output logic [N_BOTOES-1:0] leds,
    output logic [3:0]          db_estado,
    output logic [AW-1:0]       db_rodada,
    output logic [AW-1:0]       db_endereco
);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h3,
        COMPARA     = 4'h4,
        PROXIMA     = 4'h5,
        PROX_RODADA = 4'h7,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    localparam logic [AW-1:0] ULTIMA_RODADA = AW'(N_JOGADAS - 1);

    estado_t             estado;
    estado_t             proximo;
    logic [AW-1:0]       rodada;
    logic [AW-1:0]       endereco;
    logic [N_BOTOES-1:0] leds_reg;
    logic                historico;
    logic                jogada;
    logic                final_estado;
    logic                fim_contagem;
    logic [N_BOTOES-1:0] memoria [N_JOGADAS];

    assign final_estado = (estado == FIM_ACERTO) || (estado == FIM_ERRO) ||
                          (estado == FIM_TIMEOUT);

`ifdef JOGO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
    logic [CW-1:0] contador;

    // Counter only runs while waiting for a play, so every entry to ESPERA starts from zero.
    always_ff @(posedge clock) begin
        if (!reset || estado != ESPERA) begin
            contador <= '0;
        end else begin
            contador <= contador + 1'b1;
        end
    end

    assign fim_contagem = (contador == CW'(TIMEOUT_CICLOS - 1));
    assign timeout      = (estado == FIM_TIMEOUT);
`else
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT_CICLOS > 0);
    assign fim_contagem         = 1'b0;
    assign timeout              = 1'b0;
`endif

    // Sequence memory survives reset and may only be loaded while no game is running.
    always_ff @(posedge clock) begin
        if (mem_escreve && (estado == INICIAL || final_estado)) begin
            memoria[mem_endereco] <= mem_dado;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            INICIAL:     if (iniciar) proximo = PREPARA;
            PREPARA:     proximo = ESPERA;
            ESPERA: begin
                if (jogada) begin
                    proximo = REGISTRA;
                end else if (fim_contagem) begin
                    proximo = FIM_TIMEOUT;
                end
            end
            REGISTRA:    proximo = COMPARA;
            COMPARA: begin
                if (!$onehot(leds_reg) || leds_reg != memoria[endereco]) begin
                    proximo = FIM_ERRO;
                end else if (endereco < rodada) begin
                    proximo = PROXIMA;
                end else if (rodada == ULTIMA_RODADA) begin
                    proximo = FIM_ACERTO;
                end else begin
                    proximo = PROX_RODADA;
                end
            end
            PROXIMA:     proximo = ESPERA;
            PROX_RODADA: proximo = ESPERA;
            FIM_ACERTO,
            FIM_ERRO,
            FIM_TIMEOUT: if (iniciar) proximo = PREPARA;
            default:     proximo = INICIAL;
        endcase
    end

    // A play is the first cycle any button is down after all were released.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado    <= INICIAL;
            rodada    <= '0;
            endereco  <= '0;
            leds_reg  <= '0;
            historico <= 1'b0;
            jogada    <= 1'b0;
        end else begin
            estado    <= proximo;
            historico <= |botoes;
            jogada    <= (|botoes) & ~historico;
            case (estado)
                PREPARA: begin
                    rodada   <= '0;
                    endereco <= '0;
                    leds_reg <= '0;
                end
                REGISTRA:    leds_reg <= botoes;
                PROXIMA:     endereco <= endereco + 1'b1;
                PROX_RODADA: begin
                    rodada   <= rodada + 1'b1;
                    endereco <= '0;
                end
                default: ;
            endcase
        end
    end

    assign acertou     = (estado == FIM_ACERTO);
    assign errou       = (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
    assign pronto      = final_estado;
    assign leds        = leds_reg;
    assign db_estado   = estado;
    assign db_rodada   = rodada;
    assign db_endereco = endereco;

endmodule
